// File: rtl/common_tcam_wr_pkg.sv
// Shared defaults and helpers for the TCAM write-side block.
// Imported by the interface, the free-slot picker and the top.
package common_tcam_wr_pkg;

    localparam int TCAM_DEPTH_DEF = 4;
    localparam int TCAM_WIDTH_DEF = 8;

    // Index width; never below 1 so a degenerate depth still elaborates.
    function automatic int tcam_addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/common_tcam_wr_if.sv
// Command and state bus between a TCAM owner and its write side.
// The master issues insert/invalidate/flush; the slave exports storage.
interface common_tcam_wr_if
    import common_tcam_wr_pkg::*;
#(
    parameter int CAM_DEPTH = TCAM_DEPTH_DEF,
    parameter int CAM_WIDTH = TCAM_WIDTH_DEF
);
    localparam int ADDR_W = tcam_addr_w(CAM_DEPTH);

    logic                          ins_valid;
    logic                          ins_ready;
    logic [CAM_WIDTH-1:0]          ins_tag;
    logic                          inv_en;
    logic [ADDR_W-1:0]             inv_addr;
    logic                          flush;
    logic [CAM_DEPTH*CAM_WIDTH-1:0] tdata;
    logic [CAM_DEPTH-1:0]          dvalid;
    logic                          alloc_valid;
    logic [ADDR_W-1:0]             alloc_addr;
    logic                          alloc_evict;
    logic [CAM_WIDTH-1:0]          evict_tag;
    logic [ADDR_W:0]               occupancy;

    modport master (
        output ins_valid, ins_tag, inv_en, inv_addr, flush,
        input  ins_ready, tdata, dvalid,
        input  alloc_valid, alloc_addr, alloc_evict,
        input  evict_tag, occupancy
    );

    modport slave (
        input  ins_valid, ins_tag, inv_en, inv_addr, flush,
        output ins_ready, tdata, dvalid,
        output alloc_valid, alloc_addr, alloc_evict,
        output evict_tag, occupancy
    );

endinterface

// File: rtl/common_tcam_wr_freesel.sv
// Lowest-index invalid entry picker for TCAM allocation.
module common_tcam_wr_freesel
    import common_tcam_wr_pkg::*;
#(
    parameter int CAM_DEPTH = TCAM_DEPTH_DEF,
    localparam int ADDR_W   = tcam_addr_w(CAM_DEPTH)
) (
    input  logic [CAM_DEPTH-1:0] dvalid,
    output logic [CAM_DEPTH-1:0] free_oh,
    output logic [ADDR_W-1:0]    free_addr,
    output logic                 any_free
);

    // Adding one ripples through the low run of ones and lands on the
    // first zero; masking with the inverse keeps exactly that bit.
    assign free_oh  = ~dvalid & (dvalid + CAM_DEPTH'(1));
    assign any_free = ~&dvalid;

    macro_encoder_onehot_bin #(
        .N (CAM_DEPTH),
        .W (ADDR_W)
    ) u_enc (
        .onehot (free_oh),
        .bin    (free_addr)
    );

endmodule

// File: rtl/macro_encoder_onehot_bin.sv
// One-hot to binary encoder; an all-zero input encodes to 0.
module macro_encoder_onehot_bin #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] onehot,
    output logic [W-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                bin = bin | W'(i);
            end
        end
    end

endmodule

// File: rtl/common_tcam_wr.sv
// TCAM write side: tag/valid storage, fill-then-round-robin allocation,
// invalidate-by-address and flush, with a registered allocation report.
module common_tcam_wr
    import common_tcam_wr_pkg::*;
#(
    parameter int CAM_DEPTH = TCAM_DEPTH_DEF,
    parameter int CAM_WIDTH = TCAM_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    common_tcam_wr_if.slave   bus
);

    localparam int ADDR_W = tcam_addr_w(CAM_DEPTH);

    typedef logic [CAM_DEPTH-1:0][CAM_WIDTH-1:0] tag_arr_t;

    tag_arr_t             tag_q, tag_d;
    logic [CAM_DEPTH-1:0] dvalid_q, dvalid_d;
    logic [ADDR_W-1:0]    vptr_q, vptr_d;
    logic [ADDR_W:0]      occ_q;

    logic                 alloc_valid_q;
    logic [ADDR_W-1:0]    alloc_addr_q;
    logic                 alloc_evict_q;
    logic [CAM_WIDTH-1:0] evict_tag_q;

    logic [CAM_DEPTH-1:0] free_oh;
    logic [ADDR_W-1:0]    free_addr;
    logic                 any_free;

    logic                 ins_fire;
    logic                 inv_hit;
    logic [CAM_DEPTH-1:0] vptr_oh;
    logic [CAM_DEPTH-1:0] wr_oh;
    logic [ADDR_W-1:0]    tgt;

    function automatic logic [ADDR_W:0] popcnt(
        input logic [CAM_DEPTH-1:0] v
    );
        logic [ADDR_W:0] n;
        n = '0;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            n = n + (ADDR_W+1)'(v[i]);
        end
        return n;
    endfunction

    common_tcam_wr_freesel #(
        .CAM_DEPTH (CAM_DEPTH)
    ) u_freesel (
        .dvalid    (dvalid_q),
        .free_oh   (free_oh),
        .free_addr (free_addr),
        .any_free  (any_free)
    );

    assign bus.ins_ready = ~bus.flush;
    assign ins_fire      = bus.ins_valid & ~bus.flush;

    assign inv_hit = bus.inv_en &&
        ({1'b0, bus.inv_addr} < (ADDR_W+1)'(CAM_DEPTH));

    // Target comes from pre-edge valid bits, so a same-cycle
    // invalidate never opens a slot for this insert.
    assign vptr_oh = CAM_DEPTH'(1) << vptr_q;
    assign wr_oh   = any_free ? free_oh : vptr_oh;
    assign tgt     = any_free ? free_addr : vptr_q;

    always_comb begin
        dvalid_d = dvalid_q;
        tag_d    = tag_q;
        if (bus.flush) begin
            dvalid_d = '0;
        end else begin
            if (inv_hit) begin
                dvalid_d[bus.inv_addr] = 1'b0;
            end
            // Applied after the invalidate so the insert wins a collision.
            if (ins_fire) begin
                dvalid_d = dvalid_d | wr_oh;
                for (int i = 0; i < CAM_DEPTH; i++) begin
                    if (wr_oh[i]) begin
                        tag_d[i] = bus.ins_tag;
                    end
                end
            end
        end
    end

    always_comb begin
        vptr_d = vptr_q;
        if (ins_fire && !any_free) begin
            if (vptr_q == ADDR_W'(CAM_DEPTH-1)) begin
                vptr_d = '0;
            end else begin
                vptr_d = vptr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_q         <= '0;
            dvalid_q      <= '0;
            vptr_q        <= '0;
            occ_q         <= '0;
            alloc_valid_q <= 1'b0;
            alloc_addr_q  <= '0;
            alloc_evict_q <= 1'b0;
            evict_tag_q   <= '0;
        end else begin
            tag_q         <= tag_d;
            dvalid_q      <= dvalid_d;
            vptr_q        <= vptr_d;
            occ_q         <= popcnt(dvalid_d);
            alloc_valid_q <= ins_fire;
            if (ins_fire) begin
                alloc_addr_q  <= tgt;
                alloc_evict_q <= ~any_free;
                evict_tag_q   <= any_free ? '0 : tag_q[vptr_q];
            end
        end
    end

    assign bus.tdata       = tag_q;
    assign bus.dvalid      = dvalid_q;
    assign bus.occupancy   = occ_q;
    assign bus.alloc_valid = alloc_valid_q;
    assign bus.alloc_addr  = alloc_addr_q;
    assign bus.alloc_evict = alloc_evict_q;
    assign bus.evict_tag   = evict_tag_q;

endmodule
